// File: rtl/pc_fetch_ctrl.sv
// Program-counter fetch controller: IDLE/RUN/HALT sequencing with Y86-style status reporting.
// Define PC_PERF_CNT_EN to build the saturating cycle/instruction performance counters.
module pc_fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stall,
  input  logic [63:0] pc_next,
  input  logic [3:0]  icode,
  input  logic        instr_valid,
  input  logic        imem_error,
  input  logic        dmem_error,
  output logic [63:0] pc,
  output logic [2:0]  stat,
  output logic        running,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instr_cnt
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StHalt = 2'd2;

  localparam logic [2:0] StatAok = 3'd1;
  localparam logic [2:0] StatHlt = 3'd2;
  localparam logic [2:0] StatAdr = 3'd3;
  localparam logic [2:0] StatIns = 3'd4;

  logic [1:0]  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [2:0]  stat_q, stat_d;
  logic        running_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stat_d  = stat_q;
    case (state_q)
      StIdle: begin
        if (start) state_d = StRun;
      end
      StRun: begin
        if (!stall) begin
          if (imem_error || dmem_error) begin
            stat_d  = StatAdr;
            state_d = StHalt;
          end else if (!instr_valid) begin
            stat_d  = StatIns;
            state_d = StHalt;
          end else if (icode == 4'h0) begin
            stat_d  = StatHlt;
            state_d = StHalt;
          end else begin
            pc_d = pc_next;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      stat_q    <= StatAok;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      stat_q    <= stat_d;
      running_q <= (state_d == StRun);
    end
  end

  assign pc      = pc_q;
  assign stat    = stat_q;
  assign running = running_q;

`ifdef PC_PERF_CNT_EN
  logic [63:0] cycle_cnt_q, cycle_cnt_d;
  logic [63:0] instr_cnt_q, instr_cnt_d;
  logic        retire;

  // An instruction retires only when it completes normally and the PC advances.
  assign retire = (state_q == StRun) && !stall && !imem_error && !dmem_error &&
                  instr_valid && (icode != 4'h0);

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if ((state_q == StRun) && (cycle_cnt_q != '1)) cycle_cnt_d = cycle_cnt_q + 64'd1;
    if (retire && (instr_cnt_q != '1))             instr_cnt_d = instr_cnt_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`else
  assign cycle_cnt = 64'h0;
  assign instr_cnt = 64'h0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the fetch controller.
module tb_pc_fetch_ctrl;

  localparam logic [63:0] ResetPc = 64'h100;
`ifdef PC_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, stall, instr_valid, imem_error, dmem_error;
  logic [63:0] pc_next;
  logic [3:0]  icode;
  logic [63:0] pc, cycle_cnt, instr_cnt;
  logic [2:0]  stat;
  logic        running;

  int checks = 0;
  int errors = 0;

  // Reference model: mode is "idle", "run" or "halt".
  string       m_mode;
  logic [63:0] m_pc, m_cyc, m_ins;
  logic [2:0]  m_stat;

  pc_fetch_ctrl #(.RESET_PC(ResetPc)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .pc_next(pc_next),
    .icode(icode), .instr_valid(instr_valid), .imem_error(imem_error),
    .dmem_error(dmem_error), .pc(pc), .stat(stat), .running(running),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] sat_inc(input logic [63:0] v);
    return (v == 64'hFFFF_FFFF_FFFF_FFFF) ? v : v + 64'd1;
  endfunction

  // Advance one clock edge and the model with the inputs currently applied; outputs settle #1 later.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_mode = "idle"; m_pc = ResetPc; m_stat = 3'd1; m_cyc = '0; m_ins = '0;
    end else if (m_mode == "idle") begin
      if (start) m_mode = "run";
    end else if (m_mode == "run") begin
      if (PerfEn) m_cyc = sat_inc(m_cyc);
      if (!stall) begin
        if (imem_error || dmem_error) begin m_stat = 3'd3; m_mode = "halt"; end
        else if (!instr_valid)        begin m_stat = 3'd4; m_mode = "halt"; end
        else if (icode == 4'h0)       begin m_stat = 3'd2; m_mode = "halt"; end
        else begin
          m_pc = pc_next;
          if (PerfEn) m_ins = sat_inc(m_ins);
        end
      end
    end
    #1;
  endtask

  task automatic drive_idle();
    reset = 0; start = 0; stall = 0; pc_next = '0; icode = 4'h3;
    instr_valid = 1; imem_error = 0; dmem_error = 0;
  endtask

  task automatic do_reset();
    reset = 1; tick(); reset = 0;
  endtask

  task automatic test_reset();
    drive_idle();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pc_next = {$urandom, $urandom}; imem_error = 1; icode = 4'h0; instr_valid = 0;
      tick();
      checks++;
      if (pc !== 64'h100 || stat !== 3'd1 || running !== 1'b0 ||
          cycle_cnt !== 64'h0 || instr_cnt !== 64'h0) begin
        errors++;
        $display("FAIL reset_idle cyc%0d got pc=%h stat=%0d run=%b cc=%0d ic=%0d want pc=100 stat=1 run=0 cc=0 ic=0",
                 i, pc, stat, running, cycle_cnt, instr_cnt);
      end
    end
  endtask

  task automatic test_run_basic();
    drive_idle(); do_reset();
    start = 1; tick(); start = 0;
    checks++;
    if (running !== 1'b1 || pc !== 64'h100) begin
      errors++; $display("FAIL start got run=%b pc=%h want run=1 pc=100", running, pc);
    end
    icode = 4'h3; instr_valid = 1; pc_next = 64'h10A; tick();
    checks++;
    if (pc !== 64'h10A || stat !== 3'd1) begin
      errors++; $display("FAIL run_first got pc=%h stat=%0d want pc=10a stat=1", pc, stat);
    end
    pc_next = 64'h114; tick();
    checks++;
    if (pc !== 64'h114 || instr_cnt !== (PerfEn ? 64'd2 : 64'd0)) begin
      errors++; $display("FAIL run_second got pc=%h ic=%0d want pc=114 ic=%0d",
                         pc, instr_cnt, PerfEn ? 2 : 0);
    end
  endtask

  task automatic test_stall();
    stall = 1; imem_error = 1; pc_next = 64'h200;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc !== 64'h114 || stat !== 3'd1 || running !== 1'b1) begin
        errors++; $display("FAIL stall_hold cyc%0d got pc=%h stat=%0d run=%b want pc=114 stat=1 run=1",
                           i, pc, stat, running);
      end
    end
    stall = 0; imem_error = 0; tick();
    checks++;
    if (pc !== 64'h200 || stat !== 3'd1) begin
      errors++; $display("FAIL stall_release got pc=%h stat=%0d want pc=200 stat=1", pc, stat);
    end
  endtask

  task automatic test_error_priority();
    imem_error = 1; instr_valid = 0; icode = 4'h0; pc_next = 64'h300; tick();
    checks++;
    if (stat !== 3'd3 || running !== 1'b0 || pc !== 64'h200) begin
      errors++; $display("FAIL adr_priority got stat=%0d run=%b pc=%h want stat=3 run=0 pc=200",
                         stat, running, pc);
    end
    for (int i = 0; i < 10; i++) begin
      start = 1; stall = $urandom_range(0, 1); pc_next = {$urandom, $urandom};
      imem_error = $urandom_range(0, 1); dmem_error = $urandom_range(0, 1);
      instr_valid = $urandom_range(0, 1); icode = 4'($urandom);
      tick();
      checks++;
      if (stat !== 3'd3 || running !== 1'b0 || pc !== 64'h200) begin
        errors++; $display("FAIL halt_frozen cyc%0d got stat=%0d run=%b pc=%h want stat=3 run=0 pc=200",
                           i, stat, running, pc);
      end
    end
    drive_idle(); do_reset(); start = 1; tick(); start = 0;
    instr_valid = 0; icode = 4'h0; tick();
    checks++;
    if (stat !== 3'd4 || running !== 1'b0) begin
      errors++; $display("FAIL ins_over_hlt got stat=%0d run=%b want stat=4 run=0", stat, running);
    end
  endtask

  task automatic test_halt_reset();
    drive_idle(); do_reset(); start = 1; tick(); start = 0;
    pc_next = 64'h40; tick();
    icode = 4'h0; pc_next = 64'h80; tick();
    checks++;
    if (stat !== 3'd2 || pc !== 64'h40 || running !== 1'b0) begin
      errors++; $display("FAIL hlt got stat=%0d pc=%h run=%b want stat=2 pc=40 run=0", stat, pc, running);
    end
    reset = 1; start = 1; tick(); reset = 0; start = 0;
    checks++;
    if (stat !== 3'd1 || pc !== ResetPc || running !== 1'b0 || instr_cnt !== 64'h0) begin
      errors++; $display("FAIL hlt_reset got stat=%0d pc=%h run=%b ic=%0d want stat=1 pc=100 run=0 ic=0",
                         stat, pc, running, instr_cnt);
    end
    icode = 4'h3; start = 1; tick(); start = 0;
    pc_next = 64'hFFFF_FFFF_FFFF_FFFF; tick();
    checks++;
    if (pc !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL pc_all_ones got pc=%h want pc=ffffffffffffffff", pc);
    end
    reset = 1; start = 1; pc_next = 64'h999; tick(); reset = 0; start = 0;
    checks++;
    if (pc !== ResetPc || running !== 1'b0) begin
      errors++; $display("FAIL run_reset got pc=%h run=%b want pc=100 run=0", pc, running);
    end
  endtask

  task automatic test_counters();
    drive_idle(); do_reset(); start = 1; tick(); start = 0;
    pc_next = 64'h10; tick();
    stall = 1; tick(); stall = 0;
    pc_next = 64'h20; tick();
    icode = 4'h0; tick();
    icode = 4'h3; tick(); tick();
    checks++;
    if (cycle_cnt !== (PerfEn ? 64'd4 : 64'd0) || instr_cnt !== (PerfEn ? 64'd2 : 64'd0) ||
        stat !== 3'd2 || pc !== 64'h20) begin
      errors++; $display("FAIL counters got cc=%0d ic=%0d stat=%0d pc=%h want cc=%0d ic=%0d stat=2 pc=20",
                         cycle_cnt, instr_cnt, stat, pc, PerfEn ? 4 : 0, PerfEn ? 2 : 0);
    end
  endtask

  task automatic test_random();
    for (int ep = 0; ep < 12; ep++) begin
      drive_idle(); do_reset();
      for (int i = 0; i < 60; i++) begin
        reset       = ($urandom_range(0, 99) < 2);
        start       = ($urandom_range(0, 3) == 0);
        stall       = ($urandom_range(0, 3) == 0);
        imem_error  = ($urandom_range(0, 99) < 3);
        dmem_error  = ($urandom_range(0, 99) < 3);
        instr_valid = ($urandom_range(0, 99) >= 3);
        icode       = ($urandom_range(0, 99) < 4) ? 4'h0 : 4'($urandom_range(1, 15));
        pc_next     = ($urandom_range(0, 9) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
        tick();
        checks++;
        if (pc !== m_pc || stat !== m_stat || running !== (m_mode == "run") ||
            cycle_cnt !== m_cyc || instr_cnt !== m_ins) begin
          errors++;
          $display("FAIL random ep%0d cyc%0d got pc=%h stat=%0d run=%b cc=%0d ic=%0d want pc=%h stat=%0d run=%b cc=%0d ic=%0d",
                   ep, i, pc, stat, running, cycle_cnt, instr_cnt,
                   m_pc, m_stat, (m_mode == "run"), m_cyc, m_ins);
        end
      end
    end
  endtask

  initial begin
    drive_idle();
    reset = 1;
    test_reset();
    test_run_basic();
    test_stall();
    test_error_priority();
    test_halt_reset();
    test_counters();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
